// File: rtl/sb_pkg.sv
// sb_pkg: shared types and constants for the two-master system bus arbiter.
package sb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } sb_state_t;

  localparam int SLOT_DMEM = 0;
  localparam int SLOT_PS2  = 3;
  localparam int SLOT_VGA  = 7;

  localparam logic [7:0] SB_SLV_MASK =
    8'((1 << SLOT_DMEM) | (1 << SLOT_PS2) | (1 << SLOT_VGA));

  localparam logic [31:0] SB_TIMEOUT_RD = 32'hDEAD_BEEF;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        mid;
  } sb_cmd_t;

endpackage

// File: rtl/sb_rr_pick.sv
// sb_rr_pick: two-way round-robin picker; on a tie the master
// that did not win last time is chosen.
module sb_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    grant = 1'b0;
    valid = |req;
    unique case (1'b1)
      (req == 2'b11): grant = ~last;
      (req == 2'b10): grant = 1'b1;
      default:        grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/sys_bus_arbiter.sv
// sys_bus_arbiter: two-master round-robin system bus with slot decode,
// per-slot ready completion and sticky timeout/unmapped error capture.
module sys_bus_arbiter
  import sb_pkg::*;
#(
  parameter int                 NUM_SLV  = 8,
  parameter logic [NUM_SLV-1:0] SLV_MASK = SB_SLV_MASK,
  parameter int                 TIMEOUT  = 15
) (
  input  logic                 clk_i,
  input  logic                 resetn_i,
  input  logic                 m0_req_i,
  input  logic                 m0_we_i,
  input  logic [3:0]           m0_be_i,
  input  logic [31:0]          m0_addr_i,
  input  logic [31:0]          m0_wd_i,
  output logic [31:0]          m0_rd_o,
  output logic                 m0_ready_o,
  input  logic                 m1_req_i,
  input  logic                 m1_we_i,
  input  logic [3:0]           m1_be_i,
  input  logic [31:0]          m1_addr_i,
  input  logic [31:0]          m1_wd_i,
  output logic [31:0]          m1_rd_o,
  output logic                 m1_ready_o,
  output logic [NUM_SLV-1:0]   slv_req_o,
  output logic                 slv_we_o,
  output logic [3:0]           slv_be_o,
  output logic [31:0]          slv_addr_o,
  output logic [31:0]          slv_wd_o,
  input  logic [32*NUM_SLV-1:0] slv_rd_i,
  input  logic [NUM_SLV-1:0]   slv_ready_i,
  output logic                 err_o,
  output logic [31:0]          err_addr_o
);

  localparam int SW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  sb_state_t     state;
  sb_state_t     next_state;
  sb_cmd_t       cmd;
  sb_cmd_t       pick_cmd;
  logic          last_grant;
  logic          pick_id;
  logic          pick_vld;
  logic          pick_map;
  logic [7:0]    pick_slot;
  logic [SW-1:0] slot;
  logic [CW-1:0] tmo_cnt;
  logic [CW-1:0] next_cnt;
  logic [31:0]   rd_arr [NUM_SLV];
  logic          sel_ready;
  logic [31:0]   sel_rd;
  logic          access;
  logic          rd_load;
  logic          rd_mid;
  logic [31:0]   rd_val;
  logic          err_set;
  logic [31:0]   err_at;
  logic          err;
  logic [31:0]   err_addr;
  logic [31:0]   rd0;
  logic [31:0]   rd1;

  sb_rr_pick u_pick (
    .req   ({m1_req_i, m0_req_i}),
    .last  (last_grant),
    .grant (pick_id),
    .valid (pick_vld)
  );

  always_comb begin
    if (pick_id) begin
      pick_cmd = '{we: m1_we_i, be: m1_be_i, addr: m1_addr_i,
                   wd: m1_wd_i, mid: 1'b1};
    end else begin
      pick_cmd = '{we: m0_we_i, be: m0_be_i, addr: m0_addr_i,
                   wd: m0_wd_i, mid: 1'b0};
    end
  end

  assign pick_slot = pick_cmd.addr[31:24];
  assign pick_map  = (pick_slot < 8'(NUM_SLV)) &&
                     SLV_MASK[pick_slot[SW-1:0]];

  for (genvar i = 0; i < NUM_SLV; i++) begin : g_rd
    assign rd_arr[i] = slv_rd_i[32*i +: 32];
  end

  // Only mapped slots ever reach ACCESS, so the low slot bits suffice.
  assign slot      = cmd.addr[24 +: SW];
  assign sel_ready = slv_ready_i[slot];
  assign sel_rd    = rd_arr[slot];
  assign access    = (state == ACCESS);

  always_comb begin
    next_state = state;
    next_cnt   = tmo_cnt;
    rd_load    = 1'b0;
    rd_mid     = cmd.mid;
    rd_val     = '0;
    err_set    = 1'b0;
    err_at     = cmd.addr;
    unique case (state)
      IDLE: begin
        next_cnt = '0;
        if (pick_vld) begin
          if (pick_map) begin
            next_state = ACCESS;
          end else begin
            next_state = RESP;
            rd_load    = 1'b1;
            rd_mid     = pick_id;
            err_set    = 1'b1;
            err_at     = pick_cmd.addr;
          end
        end
      end
      ACCESS: begin
        if (sel_ready) begin
          next_state = RESP;
          rd_load    = 1'b1;
          rd_val     = cmd.we ? '0 : sel_rd;
        end else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
          next_state = RESP;
          rd_load    = 1'b1;
          rd_val     = SB_TIMEOUT_RD;
          err_set    = 1'b1;
        end else begin
          next_cnt = tmo_cnt + CW'(1);
        end
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state      <= IDLE;
      cmd        <= '0;
      last_grant <= 1'b1;
      tmo_cnt    <= '0;
      err        <= 1'b0;
      err_addr   <= '0;
      rd0        <= '0;
      rd1        <= '0;
    end else begin
      state   <= next_state;
      tmo_cnt <= next_cnt;
      if (state == IDLE && pick_vld) begin
        cmd        <= pick_cmd;
        last_grant <= pick_id;
      end
      if (rd_load) begin
        if (rd_mid) begin
          rd1 <= rd_val;
        end else begin
          rd0 <= rd_val;
        end
      end
      // First error wins; later ones leave the captured address alone.
      if (err_set && !err) begin
        err      <= 1'b1;
        err_addr <= err_at;
      end
    end
  end

  assign slv_req_o  = access ? (NUM_SLV'(1) << slot) : '0;
  assign slv_we_o   = access & cmd.we;
  assign slv_be_o   = access ? cmd.be : 4'h0;
  assign slv_addr_o = access ? {8'h00, cmd.addr[23:0]} : 32'h0;
  assign slv_wd_o   = access ? cmd.wd : 32'h0;

  assign m0_ready_o = (state == RESP) & ~cmd.mid;
  assign m1_ready_o = (state == RESP) &  cmd.mid;
  assign m0_rd_o    = rd0;
  assign m1_rd_o    = rd1;

  assign err_o      = err;
  assign err_addr_o = err_addr;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// tb_sys_bus_arbiter: directed then random traffic checked against a
// transaction-level timing/data model of the arbiter.
module tb_sys_bus_arbiter;

  localparam int          NS     = 8;
  localparam logic [7:0]  MASK   = 8'b1000_1001;
  localparam int          TO     = 15;
  localparam int          NEVER  = 1000;
  localparam int          CYCLES = 2500;
  localparam int          RST_AT = 400;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] data;
    int          lat;
  } txn_t;

  logic            clk = 1'b0;
  logic            resetn;
  logic            req  [2];
  logic            we   [2];
  logic [3:0]      be   [2];
  logic [31:0]     addr [2];
  logic [31:0]     wd   [2];
  logic [31:0]     m0_rd;
  logic [31:0]     m1_rd;
  logic            m0_ready;
  logic            m1_ready;
  logic [NS-1:0]   slv_req;
  logic            slv_we;
  logic [3:0]      slv_be;
  logic [31:0]     slv_addr;
  logic [31:0]     slv_wd;
  logic [32*NS-1:0] slv_rd;
  logic [NS-1:0]   slv_ready;
  logic            err;
  logic [31:0]     err_addr;

  int n_chk  = 0;
  int n_fail = 0;

  txn_t q0[$];
  txn_t q1[$];
  txn_t cur [2];
  bit   pend [2];
  bit   dropped [2];
  int   last;
  bit   busy;
  int   free_from;
  int   owner;
  int   g;
  int   wend;
  int   rdy_c;
  int   done_c;
  bit   act_map;
  bit   act_err;
  logic [31:0] exp_rd;
  logic        merr;
  logic [31:0] merr_addr;
  logic [31:0] m_rd [2];
  bit   did_rst;

  always #5 clk = ~clk;

  sys_bus_arbiter dut (
    .clk_i       (clk),
    .resetn_i    (resetn),
    .m0_req_i    (req[0]),
    .m0_we_i     (we[0]),
    .m0_be_i     (be[0]),
    .m0_addr_i   (addr[0]),
    .m0_wd_i     (wd[0]),
    .m0_rd_o     (m0_rd),
    .m0_ready_o  (m0_ready),
    .m1_req_i    (req[1]),
    .m1_we_i     (we[1]),
    .m1_be_i     (be[1]),
    .m1_addr_i   (addr[1]),
    .m1_wd_i     (wd[1]),
    .m1_rd_o     (m1_rd),
    .m1_ready_o  (m1_ready),
    .slv_req_o   (slv_req),
    .slv_we_o    (slv_we),
    .slv_be_o    (slv_be),
    .slv_addr_o  (slv_addr),
    .slv_wd_o    (slv_wd),
    .slv_rd_i    (slv_rd),
    .slv_ready_i (slv_ready),
    .err_o       (err),
    .err_addr_o  (err_addr)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic bit mapped(input logic [31:0] a);
    return (a[31:24] < 8'(NS)) && MASK[a[26:24]];
  endfunction

  function automatic txn_t mk(input logic w, input logic [3:0] b,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] r, input int l);
    txn_t t;
    t.we = w; t.be = b; t.addr = a; t.wd = d; t.data = r; t.lat = l;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t       t;
    logic [7:0] sl;
    int         k;
    if ($urandom_range(0, 9) < 8) begin
      k  = $urandom_range(0, 2);
      sl = (k == 0) ? 8'd0 : (k == 1) ? 8'd3 : 8'd7;
    end else begin
      sl = 8'($urandom);
    end
    t.addr = {sl, 24'($urandom)};
    t.we   = 1'($urandom_range(0, 1));
    t.be   = 4'($urandom);
    t.wd   = $urandom;
    t.data = $urandom;
    t.lat  = ($urandom_range(0, 15) == 0) ? NEVER : $urandom_range(0, 3);
    return t;
  endfunction

  function automatic bit in_window(input int k);
    return busy && act_map && k >= g + 1 && k <= wend;
  endfunction

  initial begin
    logic [NS-1:0] want_req;
    logic [31:0]   la;
    bit            rst_now;
    bit            win;
    int            s;

    q0.push_back(mk(1'b1, 4'hF, 32'h0700_0004, 32'hCAFE_0001, 32'h0, 1));
    q0.push_back(mk(1'b0, 4'hF, 32'h0000_0010, 32'h0, 32'h1234_5678, 0));
    q0.push_back(mk(1'b0, 4'hF, 32'h0300_0020, 32'h0, 32'h5555_AAAA, NEVER));
    q0.push_back(mk(1'b1, 4'b0011, 32'h0000_0040, 32'hAABB_CCDD,
                    32'h1111_2222, 2));
    q1.push_back(mk(1'b0, 4'hF, 32'h0300_0000, 32'h0, 32'h3333_4444, 2));
    q1.push_back(mk(1'b0, 4'hF, 32'h0000_0020, 32'h0, 32'h6666_7777, 0));
    q1.push_back(mk(1'b0, 4'hF, 32'h0500_0000, 32'h0, 32'h9999_9999, 0));
    q1.push_back(mk(1'b1, 4'hF, 32'h0600_0000, 32'h1, 32'h0, 0));

    resetn    = 1'b0;
    slv_rd    = '0;
    slv_ready = '0;
    for (int m = 0; m < 2; m++) begin
      req[m] = 1'b0; we[m] = 1'b0; be[m] = '0; addr[m] = '0; wd[m] = '0;
      pend[m] = 1'b0; dropped[m] = 1'b0; m_rd[m] = '0;
    end
    last = 1; busy = 1'b0; free_from = 0; owner = 0;
    merr = 1'b0; merr_addr = '0; did_rst = 1'b0;
    g = 0; wend = 0; rdy_c = -1; done_c = 0;
    act_map = 1'b0; act_err = 1'b0; exp_rd = '0;
    repeat (3) @(negedge clk);

    for (int k = 0; k < CYCLES; k++) begin
      if (k > 0) @(negedge clk);

      win      = in_window(k);
      want_req = win ? (NS'(1) << cur[owner].addr[26:24]) : '0;
      chk("slv_req", 32'(slv_req), 32'(want_req));
      if (win) begin
        la = cur[owner].addr;
        chk("slv_addr", slv_addr, {8'h00, la[23:0]});
        chk("slv_we", 32'(slv_we), 32'(cur[owner].we));
        chk("slv_be", 32'(slv_be), 32'(cur[owner].be));
        chk("slv_wd", slv_wd, cur[owner].wd);
      end
      if (busy && k == done_c) begin
        m_rd[owner] = exp_rd;
        if (act_err && !merr) begin
          merr      = 1'b1;
          merr_addr = cur[owner].addr;
        end
      end
      chk("m0_ready", 32'(m0_ready), 32'(busy && k == done_c && owner == 0));
      chk("m1_ready", 32'(m1_ready), 32'(busy && k == done_c && owner == 1));
      chk("m0_rd", m0_rd, m_rd[0]);
      chk("m1_rd", m1_rd, m_rd[1]);
      chk("err", 32'(err), 32'(merr));
      chk("err_addr", err_addr, merr_addr);

      if (busy && k == done_c) begin
        pend[owner]    = 1'b0;
        dropped[owner] = 1'b0;
        busy           = 1'b0;
        free_from      = k + 1;
      end

      resetn  = 1'b1;
      rst_now = !did_rst && k >= RST_AT && in_window(k);
      if (rst_now) begin
        resetn  = 1'b0;
        did_rst = 1'b1;
      end

      for (int m = 0; m < 2; m++) begin
        if (!pend[m]) begin
          if (m == 0 && q0.size() > 0) begin
            cur[0] = q0.pop_front(); pend[0] = 1'b1;
          end else if (m == 1 && q1.size() > 0) begin
            cur[1] = q1.pop_front(); pend[1] = 1'b1;
          end else if (k >= 150 && $urandom_range(0, 2) == 0) begin
            cur[m] = rand_txn(); pend[m] = 1'b1;
          end
        end
        if (k >= 150 && pend[m] && busy && owner == m && k > g &&
            !dropped[m] && $urandom_range(0, 19) == 0)
          dropped[m] = 1'b1;
        req[m]  = pend[m] && !dropped[m];
        we[m]   = cur[m].we;
        be[m]   = cur[m].be;
        addr[m] = cur[m].addr;
        wd[m]   = cur[m].wd;
      end

      if (!rst_now && !busy && k >= free_from && (req[0] || req[1])) begin
        owner   = (req[0] && req[1]) ? 1 - last : (req[1] ? 1 : 0);
        last    = owner;
        busy    = 1'b1;
        g       = k;
        act_map = mapped(cur[owner].addr);
        if (!act_map) begin
          done_c  = k + 1;
          exp_rd  = 32'h0;
          act_err = 1'b1;
          rdy_c   = -1;
          wend    = k;
        end else if (cur[owner].lat >= TO) begin
          rdy_c   = -1;
          wend    = k + TO;
          done_c  = k + TO + 1;
          exp_rd  = 32'hDEAD_BEEF;
          act_err = 1'b1;
        end else begin
          rdy_c   = k + 1 + cur[owner].lat;
          wend    = rdy_c;
          done_c  = rdy_c + 1;
          exp_rd  = cur[owner].we ? 32'h0 : cur[owner].data;
          act_err = 1'b0;
        end
      end

      slv_ready = NS'($urandom);
      for (int i = 0; i < NS; i++) slv_rd[32*i +: 32] = $urandom;
      if (in_window(k)) begin
        s = int'(cur[owner].addr[26:24]);
        slv_ready[s]      = (k == rdy_c);
        slv_rd[32*s +: 32] = cur[owner].data;
      end

      if (rst_now) begin
        if (dropped[owner]) pend[owner] = 1'b0;
        dropped[0] = 1'b0;
        dropped[1] = 1'b0;
        busy       = 1'b0;
        free_from  = k + 1;
        last       = 1;
        merr       = 1'b0;
        merr_addr  = '0;
        m_rd[0]    = '0;
        m_rd[1]    = '0;
      end
    end

    chk("reset_hit", 32'(did_rst), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
